// File: rtl/split_reg.sv
// Registered 1-to-N splitter for the IOb native bus: latches the slave select per transaction,
// returns ERR_DATA with m_err on decode error or slave timeout.
module split_reg #(
    parameter int                N_SLAVES = 4,
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                SEL_W    = $clog2(N_SLAVES),
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           m_valid,
    input  logic [ADDR_W-1:0]              m_addr,
    input  logic [DATA_W-1:0]              m_wdata,
    input  logic [DATA_W/8-1:0]            m_wstrb,
    output logic [DATA_W-1:0]              m_rdata,
    output logic                           m_ready,
    output logic                           m_err,
    output logic [N_SLAVES-1:0]            s_valid,
    output logic [N_SLAVES*ADDR_W-1:0]     s_addr,
    output logic [N_SLAVES*DATA_W-1:0]     s_wdata,
    output logic [N_SLAVES*DATA_W/8-1:0]   s_wstrb,
    input  logic [N_SLAVES*DATA_W-1:0]     s_rdata,
    input  logic [N_SLAVES-1:0]            s_ready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t              state_reg, state_next;
    logic [SEL_W-1:0]    sel_reg, sel_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [STRB_W-1:0]   wstrb_reg, wstrb_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;
    logic                err_reg, err_next;
    logic [CNT_W-1:0]    count_reg, count_next;
    logic [SEL_W-1:0]    m_sel;
    logic [DATA_W-1:0]   slave_rdata [N_SLAVES];

    assign m_sel = m_addr[ADDR_W-1 -: SEL_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            sel_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            wstrb_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            wstrb_reg <= wstrb_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        wstrb_next = wstrb_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (m_valid) begin
                    if (int'(m_sel) < N_SLAVES) begin
                        state_next = REQ;
                        sel_next   = m_sel;
                        addr_next  = m_addr;
                        wdata_next = m_wdata;
                        wstrb_next = m_wstrb;
                        count_next = '0;
                    end else begin
                        state_next = RESP;
                        rdata_next = ERR_DATA;
                        err_next   = 1'b1;
                    end
                end
            end
            REQ: begin
                // Ready is checked before the timeout so a same-cycle ready still completes normally.
                if (s_ready[sel_reg]) begin
                    state_next = RESP;
                    rdata_next = slave_rdata[sel_reg];
                    err_next   = 1'b0;
                end else if ((TIMEOUT != 0) && (int'(count_reg) == TIMEOUT - 1)) begin
                    state_next = RESP;
                    rdata_next = ERR_DATA;
                    err_next   = 1'b1;
                end else begin
                    count_next = count_reg + CNT_W'(1);
                end
            end
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Each slice is registered from the next-state values, so it is live exactly while in REQ.
    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_slice
        logic                route_next;
        logic                valid_reg;
        logic [ADDR_W-1:0]   addr_out_reg;
        logic [DATA_W-1:0]   wdata_out_reg;
        logic [STRB_W-1:0]   wstrb_out_reg;

        assign route_next = (state_next == REQ) && (sel_next == SEL_W'(gi));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_reg     <= 1'b0;
                addr_out_reg  <= '0;
                wdata_out_reg <= '0;
                wstrb_out_reg <= '0;
            end else begin
                valid_reg     <= route_next;
                addr_out_reg  <= route_next ? addr_next  : '0;
                wdata_out_reg <= route_next ? wdata_next : '0;
                wstrb_out_reg <= route_next ? wstrb_next : '0;
            end
        end

        assign slave_rdata[gi]                  = s_rdata[gi*DATA_W +: DATA_W];
        assign s_valid[gi]                      = valid_reg;
        assign s_addr[gi*ADDR_W +: ADDR_W]      = addr_out_reg;
        assign s_wdata[gi*DATA_W +: DATA_W]     = wdata_out_reg;
        assign s_wstrb[gi*STRB_W +: STRB_W]     = wstrb_out_reg;
    end

    assign m_ready = (state_reg == RESP);
    assign m_err   = err_reg & m_ready;
    assign m_rdata = rdata_reg;

endmodule

// File: tb/tb_split_reg.sv
// Randomized scoreboard bench for split_reg (3 slaves, timeout 8): driver issues requests and
// plays the slaves, a monitor compares every m_ready pulse against the queued expectation.
module tb_split_reg;

    localparam int N   = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TO  = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              m_valid = 1'b0;
    logic [AW-1:0]     m_addr = '0;
    logic [DW-1:0]     m_wdata = '0;
    logic [SW-1:0]     m_wstrb = '0;
    logic [DW-1:0]     m_rdata;
    logic              m_ready;
    logic              m_err;
    logic [N-1:0]      s_valid;
    logic [N*AW-1:0]   s_addr;
    logic [N*DW-1:0]   s_wdata;
    logic [N*SW-1:0]   s_wstrb;
    logic [N*DW-1:0]   s_rdata = '0;
    logic [N-1:0]      s_ready = '0;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    n_txn = 0;
    resp_t exp_q[$];

    split_reg #(
        .N_SLAVES(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .ERR_DATA(ERR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_rdata(s_rdata), .s_ready(s_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Reference: a request errors if it decodes past the last slave or the slave answers too late.
    function automatic resp_t model(input int sel, input logic [31:0] rd, input int delay);
        resp_t r;
        if (sel >= N || delay >= TO) begin
            r.rdata = ERR;
            r.err   = 1'b1;
        end else begin
            r.rdata = rd;
            r.err   = 1'b0;
        end
        return r;
    endfunction

    function automatic int req_cycles(input int sel, input int delay);
        if (sel >= N) return 0;
        return (delay < TO) ? delay + 1 : TO;
    endfunction

    // delay = index of the REQ cycle in which the selected slave raises ready
    task automatic run_txn(input logic [31:0] addr, input logic [3:0] wstrb,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int delay, input bit hold);
        int          sel;
        int          k;
        bit          done;
        bit          late;
        resp_t       r;
        logic [N-1:0]    ev;
        logic [N*AW-1:0] ea;
        logic [N*DW-1:0] ed;
        logic [N*SW-1:0] es;
        sel = int'(addr[31:30]);
        r = model(sel, rdata, delay);
        late = (sel < N) && r.err;
        exp_q.push_back(r);
        ev = '0; ea = '0; ed = '0; es = '0;
        if (sel < N) begin
            ev[sel] = 1'b1;
            ea[sel*AW +: AW] = addr;
            ed[sel*DW +: DW] = wdata;
            es[sel*SW +: SW] = wstrb;
        end
        s_ready = '0;
        m_valid = 1'b1; m_addr = addr; m_wdata = wdata; m_wstrb = wstrb;
        k = 0; done = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(posedge clk); #1;
            s_ready = '0;
            s_rdata = {$urandom, $urandom, $urandom};
            if (m_ready) begin
                done = 1'b1;
                check("req_cycles", 128'(k), 128'(req_cycles(sel, delay)));
                if (!hold) m_valid = 1'b0;
                if (late) s_ready = ev;
            end else begin
                check("s_valid", 128'(s_valid), 128'(ev));
                check("s_addr", 128'(s_addr), 128'(ea));
                check("s_wdata", 128'(s_wdata), 128'(ed));
                check("s_wstrb", 128'(s_wstrb), 128'(es));
                s_ready = N'($urandom) & ~ev;
                if (k == delay) begin
                    s_ready = s_ready | ev;
                    s_rdata[sel*DW +: DW] = rdata;
                end
                k++;
                if ($urandom_range(0, 1) == 1) m_addr = $urandom;
            end
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL txn_wait: got no m_ready within 40 cycles, required a response");
        end
        @(posedge clk); #1;
        m_valid = 1'b0;
        s_ready = late ? ev : '0;
        @(posedge clk); #1;
        s_ready = '0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
    endtask

    task automatic reset_mid_req();
        m_valid = 1'b1; m_addr = 32'h4000_0020; m_wdata = 32'h1111_2222; m_wstrb = 4'h3;
        @(posedge clk); #1;
        check("rst_pre_valid", 128'(s_valid), 128'(3'b010));
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_s_valid", 128'(s_valid), 128'(0));
        check("rst_s_addr", 128'(s_addr), 128'(0));
        check("rst_s_wdata", 128'(s_wdata), 128'(0));
        check("rst_m_ready", 128'(m_ready), 128'(0));
        check("rst_m_rdata", 128'(m_rdata), 128'(0));
        m_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_no_resp", 128'(m_ready), 128'(0));
    endtask

    always @(negedge clk) begin
        resp_t r;
        if (rst_n) begin
            if (m_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL spurious_m_ready: got m_ready=1 rdata=%h, required no response", m_rdata);
                end else begin
                    r = exp_q.pop_front();
                    check("m_rdata", 128'(m_rdata), 128'(r.rdata));
                    check("m_err", 128'(m_err), 128'(r.err));
                    n_txn++;
                    $display("txn %0d: rdata=%h err=%b", n_txn, m_rdata, m_err);
                end
            end else begin
                check("m_err_quiet", 128'(m_err), 128'(0));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_s_valid", 128'(s_valid), 128'(0));
        check("reset_m_ready", 128'(m_ready), 128'(0));
        check("reset_m_rdata", 128'(m_rdata), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(32'h8000_0010, 4'h0, 32'h0,         32'h1234_5678, 2,  1'b0);
        run_txn(32'h4000_0004, 4'hF, 32'hA5A5_A5A5, 32'h0BAD_F00D, 0,  1'b0);
        run_txn(32'hC000_0000, 4'h0, 32'h0,         32'h5555_AAAA, 0,  1'b1);
        run_txn(32'h0000_0100, 4'h0, 32'h0,         32'h7777_7777, 99, 1'b0);
        run_txn(32'h8000_0000, 4'h1, 32'hCAFE_0001, 32'h2468_ACE0, TO - 1, 1'b0);
        run_txn(32'h0000_0040, 4'h0, 32'h0,         32'h1357_9BDF, TO, 1'b1);
        reset_mid_req();
        run_txn(32'h4000_0008, 4'h0, 32'h0,         32'h0F0F_0F0F, 1,  1'b0);

        for (int i = 0; i < 150; i++) begin
            run_txn($urandom, 4'($urandom), $urandom, $urandom,
                    $urandom_range(0, 10), 1'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clk);
        #1;
        check("queue_empty", 128'(exp_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
